// File: rtl/mc_control_fsm_m_if.sv
// Control bus between the multi-cycle MIPS control FSM (master) and the datapath (slave).
interface mc_control_fsm_m_if #(
  parameter int unsigned OP_W       = 6,
  parameter int unsigned ALU_CTRL_W = 3
) ();
  logic [OP_W-1:0]       op;
  logic [OP_W-1:0]       funct;
  logic                  zero;
  logic                  pc_en;
  logic                  ir_write;
  logic                  mem_write;
  logic                  reg_write;
  logic                  iord;
  logic                  mem_to_reg;
  logic                  reg_dst;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            pc_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal_op;

  modport master (
    input  op, funct, zero,
    output pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op
  );

  modport slave (
    output op, funct, zero,
    input  pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op
  );
endinterface

// File: rtl/mc_control_fsm_m.sv
// Moore control FSM of the multi-cycle MIPS core: sequences FETCH/DECODE and the per-opcode states.
// Optional macro MC_BNE_EN adds bne (op 000101) through the BRANCH state with inverted zero.
module mc_control_fsm_m #(
  parameter int unsigned OP_W       = 6,
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mc_control_fsm_m_if.master   bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MC_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

  logic [3:0]            r_state;
  logic [3:0]            w_next;
  logic                  w_pc_write;
  logic                  w_branch;
  logic                  w_take;
  logic                  w_ir_write;
  logic                  w_mem_write;
  logic                  w_reg_write;
  logic                  w_iord;
  logic                  w_mem_to_reg;
  logic                  w_reg_dst;
  logic                  w_alu_src_a;
  logic [1:0]            w_alu_src_b;
  logic [1:0]            w_pc_src;
  logic [ALU_CTRL_W-1:0] w_alu_ctrl;
  logic                  w_illegal;
  logic [ALU_CTRL_W-1:0] w_funct_alu;
  logic                  w_funct_ok;

  // State register; any encoding falls back to FETCH through the next-state default.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

`ifdef MC_BNE_EN
  // BRANCH must not look at op, so the bne/beq choice is captured while in DECODE.
  logic r_bne;
  always_ff @(posedge clk) begin
    if (rst)                        r_bne <= 1'b0;
    else if (r_state == S_DECODE)   r_bne <= (bus.op == OP_BNE);
  end
  assign w_take = r_bne ? ~bus.zero : bus.zero;
`else
  assign w_take = bus.zero;
`endif

  // R-type funct decode, shared by EXECUTE (ALU code) and DECODE (illegal check).
  always_comb begin
    w_funct_alu = ALU_ADD;
    w_funct_ok  = 1'b1;
    case (bus.funct)
      FN_ADD:  w_funct_alu = ALU_ADD;
      FN_SUB:  w_funct_alu = ALU_SUB;
      FN_AND:  w_funct_alu = ALU_AND;
      FN_OR:   w_funct_alu = ALU_OR;
      FN_SLT:  w_funct_alu = ALU_SLT;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_iord       = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_src     = 2'b00;
    w_alu_ctrl   = ALU_ADD;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b = 2'b01;
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            w_next    = S_EXECUTE;
            w_illegal = ~w_funct_ok;
          end
          OP_BEQ:  w_next = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:  w_next = S_BRANCH;
`endif
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JUMP;
          default: w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = w_funct_alu;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = ALU_SUB;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables, strobes and the illegal pulse are held low while reset is asserted.
  assign bus.pc_en       = ~rst & (w_pc_write | (w_branch & w_take));
  assign bus.ir_write    = ~rst & w_ir_write;
  assign bus.mem_write   = ~rst & w_mem_write;
  assign bus.reg_write   = ~rst & w_reg_write;
  assign bus.illegal_op  = ~rst & w_illegal;
  assign bus.iord        = w_iord;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.pc_src      = w_pc_src;
  assign bus.alu_control = w_alu_ctrl;

endmodule
